// File: rtl/rx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_pkg
// Description : Shared types and CRC_A constants for the ISO 14443A RX path.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_frame_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        READY     = 2'd2
    } rx_state_e;

    localparam logic [15:0] CRC_A_INIT    = 16'h6363;
    localparam logic [15:0] CRC_A_POLY    = 16'h8408;
    localparam logic [15:0] CRC_A_RESIDUE = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/crc_a_byte.sv
`default_nettype none
// ============================================================================
// Module      : crc_a_byte
// Description : Combinational CRC_A update for one byte, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_a_byte
    import rx_frame_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_work;

    always_comb begin
        crc_work = crc_i ^ {8'h00, data_i};
        for (int i = 0; i < 8; i++) begin
            crc_work = crc_work[0] ? ((crc_work >> 1) ^ CRC_A_POLY) : (crc_work >> 1);
        end
        crc_o = crc_work;
    end

endmodule
`default_nettype wire

// File: rtl/rx_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_controller
// Description : Buffers one decoded frame, checks CRC_A, holds it until ack.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_controller
    import rx_frame_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int ADDR_W    = $clog2(MAX_BYTES),
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_soc,
    input  logic              rx_eoc,
    input  logic              rx_data_valid,
    input  logic [7:0]        rx_data,
    input  logic [2:0]        rx_data_bits,
    input  logic              rx_error,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              frame_ready,
    output logic [LEN_W-1:0]  frame_len,
    output logic [2:0]        frame_last_bits,
    output logic              frame_crc_ok,
    output logic              frame_error,
    input  logic              frame_ack,
    output logic              overrun
);

    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] C_MIN_CRC = LEN_W'(3);

    rx_state_e         state_q;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [15:0]       crc_q, crc_d, crc_byte;
    logic              err_q, err_d;
    logic [2:0]        last_bits_q, last_bits_d;
    logic              ready_q, crc_ok_q, overrun_q;
    logic              store_byte;
    logic [7:0]        rd_data_q;
    logic [7:0]        buf_mem [MAX_BYTES];

    crc_a_byte u_crc (
        .crc_i  (crc_q),
        .data_i (rx_data),
        .crc_o  (crc_byte)
    );

    // Effect of the current cycle's byte/error on the frame being received.
    always_comb begin
        store_byte  = 1'b0;
        count_d     = count_q;
        crc_d       = crc_q;
        err_d       = err_q;
        last_bits_d = last_bits_q;
        if (state_q == RECEIVING && !rx_soc) begin
            if (rx_error) begin
                err_d = 1'b1;
            end
            if (rx_data_valid) begin
                if (!rx_eoc && rx_data_bits != 3'd0) begin
                    err_d = 1'b1;
                end else if (count_q >= C_MAX_LEN) begin
                    err_d = 1'b1;
                end else begin
                    store_byte = 1'b1;
                    count_d    = count_q + LEN_W'(1);
                    if (rx_data_bits == 3'd0) begin
                        crc_d = crc_byte;
                    end
                end
                if (rx_eoc) begin
                    last_bits_d = rx_data_bits;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            crc_q       <= CRC_A_INIT;
            err_q       <= 1'b0;
            last_bits_q <= 3'd0;
            ready_q     <= 1'b0;
            crc_ok_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_soc) begin
                        state_q     <= RECEIVING;
                        count_q     <= '0;
                        crc_q       <= CRC_A_INIT;
                        err_q       <= 1'b0;
                        last_bits_q <= 3'd0;
                        crc_ok_q    <= 1'b0;
                    end
                end
                RECEIVING: begin
                    if (rx_soc) begin
                        count_q     <= '0;
                        crc_q       <= CRC_A_INIT;
                        err_q       <= 1'b0;
                        last_bits_q <= 3'd0;
                    end else begin
                        count_q     <= count_d;
                        crc_q       <= crc_d;
                        err_q       <= err_d;
                        last_bits_q <= last_bits_d;
                        if (rx_eoc) begin
                            state_q  <= READY;
                            ready_q  <= 1'b1;
                            crc_ok_q <= (crc_d == CRC_A_RESIDUE) && (count_d >= C_MIN_CRC)
                                        && (last_bits_d == 3'd0) && !err_d;
                        end
                    end
                end
                READY: begin
                    if (rx_soc) begin
                        overrun_q <= 1'b1;
                    end
                    if (frame_ack) begin
                        state_q  <= IDLE;
                        ready_q  <= 1'b0;
                        crc_ok_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store_byte) begin
            buf_mem[count_q[ADDR_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= buf_mem[rd_addr];
        end
    end

    assign rd_data         = rd_data_q;
    assign frame_ready     = ready_q;
    assign frame_len       = count_q;
    assign frame_last_bits = last_bits_q;
    assign frame_crc_ok    = crc_ok_q;
    assign frame_error     = err_q;
    assign overrun         = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_controller
// Description : Directed self-checking bench for rx_frame_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_controller;

    localparam int MAX_BYTES = 64;
    localparam int ADDR_W    = $clog2(MAX_BYTES);
    localparam int LEN_W     = $clog2(MAX_BYTES + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_soc, rx_eoc, rx_data_valid, rx_error, frame_ack;
    logic [7:0]        rx_data;
    logic [2:0]        rx_data_bits;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frame_ready, frame_crc_ok, frame_error, overrun;
    logic [LEN_W-1:0]  frame_len;
    logic [2:0]        frame_last_bits;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] fb [0:127];

    rx_frame_controller #(.MAX_BYTES(MAX_BYTES)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_soc          (rx_soc),
        .rx_eoc          (rx_eoc),
        .rx_data_valid   (rx_data_valid),
        .rx_data         (rx_data),
        .rx_data_bits    (rx_data_bits),
        .rx_error        (rx_error),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .frame_ready     (frame_ready),
        .frame_len       (frame_len),
        .frame_last_bits (frame_last_bits),
        .frame_crc_ok    (frame_crc_ok),
        .frame_error     (frame_error),
        .frame_ack       (frame_ack),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input logic [2:0] lbits, input int err_at, input bit err_eoc);
        rx_soc = 1'b1;
        cycle();
        rx_soc = 1'b0;
        for (int i = 0; i < n - 1; i++) begin
            rx_data_valid = 1'b1;
            rx_data       = fb[i];
            rx_data_bits  = 3'd0;
            rx_error      = (i == err_at);
            cycle();
        end
        check("ready_before_eoc", frame_ready, 0);
        rx_data_valid = 1'b1;
        rx_data       = fb[n-1];
        rx_data_bits  = lbits;
        rx_eoc        = 1'b1;
        rx_error      = err_eoc;
        cycle();
        rx_data_valid = 1'b0;
        rx_eoc        = 1'b0;
        rx_error      = 1'b0;
        rx_data_bits  = 3'd0;
    endtask

    task automatic expect_frame(input int len, input int lb, input bit crc_ok, input bit err);
        check("frame_ready", frame_ready, 1);
        check("frame_len", frame_len, len);
        check("frame_last_bits", frame_last_bits, lb);
        check("frame_crc_ok", frame_crc_ok, crc_ok);
        check("frame_error", frame_error, err);
    endtask

    task automatic read_check(input int addr, input logic [7:0] exp);
        rd_addr = ADDR_W'(addr);
        cycle();
        check("rd_data", rd_data, exp);
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        cycle();
        frame_ack = 1'b0;
        check("ready_after_ack", frame_ready, 0);
    endtask

    task automatic load4(input logic [7:0] b0, b1, b2, b3);
        fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
    endtask

    initial begin
        rst = 1'b1; rx_soc = 0; rx_eoc = 0; rx_data_valid = 0; rx_error = 0;
        frame_ack = 0; rx_data = 0; rx_data_bits = 0; rd_addr = '0;
        cycle(); cycle();
        check("rst_ready", frame_ready, 0);
        check("rst_len", frame_len, 0);
        check("rst_last_bits", frame_last_bits, 0);
        check("rst_crc_ok", frame_crc_ok, 0);
        check("rst_error", frame_error, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        cycle();

        // Reference CRC_A frame from ISO 14443-3
        load4(8'h00, 8'h00, 8'hA0, 8'h1E);
        send_frame(4, 3'd0, -1, 1'b0);
        expect_frame(4, 0, 1'b1, 1'b0);
        read_check(0, 8'h00);
        read_check(1, 8'h00);
        read_check(2, 8'hA0);
        read_check(3, 8'h1E);
        ack();

        load4(8'h12, 8'h34, 8'h26, 8'hCF);
        send_frame(4, 3'd0, -1, 1'b0);
        expect_frame(4, 0, 1'b1, 1'b0);
        ack();

        load4(8'h12, 8'h34, 8'h26, 8'hCE);
        send_frame(4, 3'd0, -1, 1'b0);
        expect_frame(4, 0, 1'b0, 1'b0);
        ack();

        fb[0] = 8'h26;
        send_frame(1, 3'd7, -1, 1'b0);
        expect_frame(1, 7, 1'b0, 1'b0);
        read_check(0, 8'h26);
        ack();

        load4(8'h00, 8'h00, 8'hA0, 8'h1E);
        send_frame(4, 3'd0, 1, 1'b0);
        expect_frame(4, 0, 1'b0, 1'b1);
        ack();

        send_frame(4, 3'd0, -1, 1'b1);
        expect_frame(4, 0, 1'b0, 1'b1);
        ack();

        for (int i = 0; i < MAX_BYTES + 2; i++) fb[i] = 8'(i + 8'h40);
        send_frame(MAX_BYTES + 2, 3'd0, -1, 1'b0);
        expect_frame(MAX_BYTES, 0, 1'b0, 1'b1);
        read_check(0, 8'h40);
        read_check(MAX_BYTES - 1, 8'(MAX_BYTES - 1 + 8'h40));
        ack();

        load4(8'h12, 8'h34, 8'h26, 8'hCF);
        send_frame(4, 3'd0, -1, 1'b0);
        rx_soc = 1'b1;
        cycle();
        rx_soc = 1'b0;
        check("overrun_pulse", overrun, 1);
        cycle();
        check("overrun_clear", overrun, 0);
        expect_frame(4, 0, 1'b1, 1'b0);
        read_check(0, 8'h12);
        ack();

        // Abandoned partial frame, then a fresh SOC mid-frame
        rx_soc = 1'b1;
        cycle();
        rx_soc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_data_valid = 1'b1;
            rx_data       = 8'hF0 + 8'(i);
            cycle();
        end
        rx_data_valid = 1'b0;
        send_frame(4, 3'd0, -1, 1'b0);
        expect_frame(4, 0, 1'b1, 1'b0);
        read_check(0, 8'h12);
        ack();

        rd_addr = '0;
        rx_soc = 1'b1;
        cycle();
        rx_soc = 1'b0;
        rx_data_valid = 1'b1;
        rx_data = 8'h55;
        cycle();
        rx_data = 8'h66;
        cycle();
        rx_data_valid = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        check("midrst_len", frame_len, 0);
        check("midrst_ready", frame_ready, 0);
        check("midrst_error", frame_error, 0);
        check("midrst_rd_data", rd_data, 0);
        check("midrst_overrun", overrun, 0);
        cycle();
        rst = 1'b0;
        cycle();
        check("post_rst_overrun", overrun, 0);
        load4(8'h00, 8'h00, 8'hA0, 8'h1E);
        send_frame(4, 3'd0, -1, 1'b0);
        expect_frame(4, 0, 1'b1, 1'b0);
        ack();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
